// File: rtl/approx_adder_error_monitor_if.sv
// Sample stream from an approximate adder into its error monitor.
// The producer drives operands, approximate sum and last-marker; the monitor returns ready.
interface approx_adder_error_monitor_if #(
  parameter int OPW = 4
);
  logic           in_valid;
  logic           in_ready;
  logic [OPW-1:0] in_a;
  logic [OPW-1:0] in_b;
  logic [OPW:0]   approx_sum;
  logic           in_last;

  modport master (
    output in_valid, in_a, in_b, approx_sum, in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_a, in_b, approx_sum, in_last,
    output in_ready
  );
endinterface

// File: rtl/approx_adder_error_monitor.sv
// Streaming error statistics for an approximate adder: per-sample |approx - exact|,
// accumulated as max, saturating sum and saturating threshold-violation count per run.
module approx_adder_error_monitor #(
  parameter int OPW     = 4,
  parameter int ERR_THR = 16,
  parameter int CNT_W   = 16,
  parameter int ACC_W   = 24
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  approx_adder_error_monitor_if.slave      s_if,
  output logic                             busy,
  output logic                             done,
  output logic [OPW:0]                     max_error,
  output logic [ACC_W-1:0]                 error_sum,
  output logic [CNT_W-1:0]                 sample_count,
  output logic [CNT_W-1:0]                 violation_count,
  output logic                             pass
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t             state_reg, state_next;
  logic               clear;
  logic               accept;
  logic [OPW:0]       exact;
  logic [OPW:0]       err_next;
  logic               viol_next;
  logic               s1_valid_reg, s2_valid_reg;
  logic [OPW:0]       s1_err_reg;
  logic               s1_viol_reg;
  logic [OPW:0]       max_error_reg;
  logic [ACC_W-1:0]   error_sum_reg;
  logic [CNT_W-1:0]   sample_count_reg, violation_count_reg;
  logic [ACC_W:0]     sum_ext;

  assign accept = s_if.in_valid && (state_reg == RUN);

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // A run only ends through an accepted in_last sample, then waits for the pipeline to empty.
  always_comb begin
    state_next    = state_reg;
    clear         = 1'b0;
    s_if.in_ready = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          clear      = 1'b1;
        end
      end
      RUN: begin
        s_if.in_ready = 1'b1;
        busy          = 1'b1;
        if (s_if.in_valid && s_if.in_last) state_next = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (!s1_valid_reg && !s2_valid_reg) state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          state_next = RUN;
          clear      = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign exact     = {1'b0, s_if.in_a} + {1'b0, s_if.in_b};
  assign err_next  = (s_if.approx_sum >= exact) ? (s_if.approx_sum - exact)
                                                : (exact - s_if.approx_sum);
  assign viol_next = 32'(err_next) > 32'(ERR_THR);
  assign sum_ext   = {1'b0, error_sum_reg} + (ACC_W+1)'(s1_err_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg        <= 1'b0;
      s2_valid_reg        <= 1'b0;
      s1_err_reg          <= '0;
      s1_viol_reg         <= 1'b0;
      max_error_reg       <= '0;
      error_sum_reg       <= '0;
      sample_count_reg    <= '0;
      violation_count_reg <= '0;
    end else begin
      s1_valid_reg <= accept;
      // s2_valid_reg marks the cycle in which stage-2 statistics have just settled.
      s2_valid_reg <= s1_valid_reg;
      if (accept) begin
        s1_err_reg  <= err_next;
        s1_viol_reg <= viol_next;
      end
      if (clear) begin
        max_error_reg       <= '0;
        error_sum_reg       <= '0;
        sample_count_reg    <= '0;
        violation_count_reg <= '0;
      end else begin
        if (accept && (sample_count_reg != '1))
          sample_count_reg <= sample_count_reg + 1'b1;
        if (s1_valid_reg) begin
          if (s1_err_reg > max_error_reg) max_error_reg <= s1_err_reg;
          error_sum_reg <= sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
          if (s1_viol_reg && (violation_count_reg != '1))
            violation_count_reg <= violation_count_reg + 1'b1;
        end
      end
    end
  end

  assign max_error       = max_error_reg;
  assign error_sum       = error_sum_reg;
  assign sample_count    = sample_count_reg;
  assign violation_count = violation_count_reg;
  assign pass            = done && (violation_count_reg == '0);

endmodule

// File: tb/tb_approx_adder_error_monitor.sv
// Drives two monitors (wide and narrow counters) with the same stream and checks
// their statistics against a queue-based reference of per-sample absolute errors.
module tb_approx_adder_error_monitor;

  logic clk = 1'b0;
  logic rst;
  logic start;
  always #5 clk = ~clk;

  approx_adder_error_monitor_if #(.OPW(4)) ifa ();
  approx_adder_error_monitor_if #(.OPW(4)) ifb ();

  assign ifb.in_valid   = ifa.in_valid;
  assign ifb.in_a       = ifa.in_a;
  assign ifb.in_b       = ifa.in_b;
  assign ifb.approx_sum = ifa.approx_sum;
  assign ifb.in_last    = ifa.in_last;

  logic        busy_a, done_a, pass_a;
  logic [4:0]  max_a;
  logic [23:0] sum_a;
  logic [15:0] cnt_a, vio_a;
  logic        busy_b, done_b, pass_b;
  logic [4:0]  max_b;
  logic [7:0]  sum_b;
  logic [3:0]  cnt_b, vio_b;

  approx_adder_error_monitor #(.OPW(4), .ERR_THR(16), .CNT_W(16), .ACC_W(24)) dut_a (
    .clk(clk), .rst(rst), .start(start), .s_if(ifa),
    .busy(busy_a), .done(done_a), .max_error(max_a), .error_sum(sum_a),
    .sample_count(cnt_a), .violation_count(vio_a), .pass(pass_a)
  );

  approx_adder_error_monitor #(.OPW(4), .ERR_THR(16), .CNT_W(4), .ACC_W(8)) dut_b (
    .clk(clk), .rst(rst), .start(start), .s_if(ifb),
    .busy(busy_b), .done(done_b), .max_error(max_b), .error_sum(sum_b),
    .sample_count(cnt_b), .violation_count(vio_b), .pass(pass_b)
  );

  int checks = 0;
  int errors = 0;
  int errs[$];
  bit exp_run  = 1'b0;
  bit exp_busy = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic longint sat(input longint v, input int w);
    longint m;
    m = (longint'(1) << w) - 1;
    return (v > m) ? m : v;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One cycle of stimulus; the reference decides acceptance from its own run/busy view.
  task automatic send(input int a, input int b, input int ap, input bit last,
                      input bit valid, input bit st);
    bit acc;
    int e;
    ifa.in_a       = 4'(a);
    ifa.in_b       = 4'(b);
    ifa.approx_sum = 5'(ap);
    ifa.in_last    = last;
    ifa.in_valid   = valid;
    start          = st;
    chk("in_ready_a", {63'd0, ifa.in_ready}, {63'd0, exp_run});
    chk("in_ready_b", {63'd0, ifb.in_ready}, {63'd0, exp_run});
    acc = valid && exp_run;
    if (st && !exp_busy) begin
      errs.delete();
      exp_run  = 1'b1;
      exp_busy = 1'b1;
    end
    if (acc) begin
      e = ap - (a + b);
      if (e < 0) e = -e;
      errs.push_back(e);
      if (last) exp_run = 1'b0;
    end
    step();
    start        = 1'b0;
    ifa.in_valid = 1'b0;
    ifa.in_last  = 1'b0;
  endtask

  task automatic check_stats();
    longint n, mx, sm, v;
    n = errs.size(); mx = 0; sm = 0; v = 0;
    foreach (errs[i]) begin
      if (errs[i] > mx) mx = errs[i];
      sm += errs[i];
      if (errs[i] > 16) v++;
    end
    chk("done_a", {63'd0, done_a}, 64'd1);
    chk("done_b", {63'd0, done_b}, 64'd1);
    chk("busy_a", {63'd0, busy_a}, 64'd0);
    chk("max_a", 64'(max_a), 64'(mx));
    chk("max_b", 64'(max_b), 64'(mx));
    chk("sum_a", 64'(sum_a), 64'(sat(sm, 24)));
    chk("sum_b", 64'(sum_b), 64'(sat(sm, 8)));
    chk("cnt_a", 64'(cnt_a), 64'(sat(n, 16)));
    chk("cnt_b", 64'(cnt_b), 64'(sat(n, 4)));
    chk("vio_a", 64'(vio_a), 64'(sat(v, 16)));
    chk("vio_b", 64'(vio_b), 64'(sat(v, 4)));
    chk("pass_a", {63'd0, pass_a}, {63'd0, v == 0});
    chk("pass_b", {63'd0, pass_b}, {63'd0, v == 0});
  endtask

  // Called right after the edge that accepted in_last: done must rise exactly 3 edges later.
  task automatic wait_done();
    for (int k = 0; k < 3; k++) begin
      chk("drain_done", {63'd0, done_a}, 64'd0);
      chk("drain_busy", {63'd0, busy_a}, 64'd1);
      chk("drain_ready", {63'd0, ifa.in_ready}, 64'd0);
      step();
    end
    exp_busy = 1'b0;
    check_stats();
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_done"}, {63'd0, done_a | done_b}, 64'd0);
    chk({tag, "_busy"}, {63'd0, busy_a | busy_b}, 64'd0);
    chk({tag, "_pass"}, {63'd0, pass_a | pass_b}, 64'd0);
    chk({tag, "_ready"}, {63'd0, ifa.in_ready | ifb.in_ready}, 64'd0);
    chk({tag, "_max"}, 64'(max_a | max_b), 64'd0);
    chk({tag, "_sum"}, 64'(sum_a | 24'(sum_b)), 64'd0);
    chk({tag, "_cnt"}, 64'(cnt_a | 16'(cnt_b)), 64'd0);
    chk({tag, "_vio"}, 64'(vio_a | 16'(vio_b)), 64'd0);
  endtask

  initial begin
    int a, b;
    rst = 1'b1; start = 1'b0;
    ifa.in_valid = 1'b0; ifa.in_last = 1'b0;
    ifa.in_a = '0; ifa.in_b = '0; ifa.approx_sum = '0;
    step(); step();
    rst = 1'b0;
    check_idle("reset");

    // Single exact sample
    send(0, 0, 0, 0, 0, 1);
    send(3, 5, 8, 1, 1, 0);
    wait_done();

    // Worst error, then the threshold boundary; start with valid in DONE is not a sample
    send(0, 0, 0, 0, 0, 1);
    send(0, 0, 31, 0, 1, 0);
    send(15, 15, 14, 1, 1, 0);
    wait_done();
    send(15, 15, 14, 1, 1, 1);
    send(15, 15, 14, 1, 1, 0);
    wait_done();

    // Exhaustive operand pairs, exact then off-by-LSB
    for (int pass_i = 0; pass_i < 2; pass_i++) begin
      send(0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 256; i++) begin
        a = i / 16; b = i % 16;
        send(a, b, (a + b) ^ pass_i, i == 255, 1, 0);
      end
      wait_done();
    end

    // Random valid gaps with ignored mid-run starts; inputs in DONE are ignored
    send(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 40; i++)
      send($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 31), 0,
           1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
    send($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 31), 1, 1, 0);
    wait_done();
    send(0, 0, 31, 1, 1, 0);
    step();
    check_stats();

    // Saturation of the narrow counters
    send(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) send(0, 0, 31, i == 19, 1, 0);
    wait_done();

    // Reset one cycle after the last accept discards the run
    send(0, 0, 0, 0, 0, 1);
    send(7, 7, 0, 0, 1, 0);
    send(1, 2, 30, 1, 1, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    errs.delete(); exp_run = 1'b0; exp_busy = 1'b0;
    check_idle("midrst");
    for (int k = 0; k < 5; k++) begin
      step();
      chk("midrst_nodone", {63'd0, done_a | done_b}, 64'd0);
    end
    send(0, 0, 0, 0, 0, 1);
    send(9, 4, 15, 0, 1, 0);
    send(2, 2, 4, 1, 1, 0);
    wait_done();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
